// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker
// Turns PS/2 mouse packets (status, dx, dy, dz) into an absolute X/Y
// position that stays inside the screen, a wrapping wheel count and the
// button state. Each packet takes three cycles after it is accepted. One
// more packet can arrive while that work is in flight; it is held in a
// one-deep pending buffer.
module mouse_position_tracker #(
  parameter int X_LIMIT  = 160,
  parameter int Y_LIMIT  = 120,
  parameter bit Y_INVERT = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic [7:0] MOUSE_DZ,
  input  logic       SEND_INTERRUPT,
  input  logic       OVERRUN_CLR,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_Z,
  output logic [2:0] BUTTONS,
  output logic       POS_VALID,
  output logic       BUSY,
  output logic       OVERRUN
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC_X = 2'd1,
    S_CALC_Y = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [7:0] dz;
  } pkt_t;

  localparam logic signed [9:0] X_MAX = 10'(X_LIMIT - 1);
  localparam logic signed [9:0] Y_MAX = 10'(Y_LIMIT - 1);
  localparam logic [7:0]        X_HOME = 8'(X_LIMIT / 2);
  localparam logic [7:0]        Y_HOME = 8'(Y_LIMIT / 2);

  state_t     r_state;
  pkt_t       r_snap;
  pkt_t       r_pend;
  logic       r_pending;
  logic [7:0] r_nx;
  logic [7:0] r_ny;
  logic [7:0] r_nz;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic [7:0] r_z;
  logic [2:0] r_buttons;
  logic       r_pos_valid;
  logic       r_overrun;

  pkt_t              w_in;
  logic signed [8:0] w_dx9;
  logic signed [8:0] w_dy9;
  logic signed [9:0] w_sx;
  logic signed [9:0] w_sy;
  logic [7:0]        w_nx;
  logic [7:0]        w_ny;
  logic [7:0]        w_nz;

  // Forces a signed 10-bit sum into the range 0..max.
  function automatic logic [7:0] clamp(input logic signed [9:0] v,
                                       input logic signed [9:0] max);
    if (v < 10'sd0)    return 8'd0;
    else if (v > max)  return max[7:0];
    else               return v[7:0];
  endfunction

  assign w_in = '{status: MOUSE_STATUS, dx: MOUSE_DX, dy: MOUSE_DY, dz: MOUSE_DZ};

  // Next-position arithmetic on the snapshot. A set overflow bit discards
  // only the delta of its own axis. Ten signed bits hold -256..+510.
  always_comb begin
    // NOTE: give every always_comb output a value on every path first; a
    // path that leaves one unassigned infers a latch.
    w_dx9 = '0;
    w_dy9 = '0;
    if (!r_snap.status[6]) w_dx9 = {r_snap.status[4], r_snap.dx};
    if (!r_snap.status[7]) w_dy9 = {r_snap.status[5], r_snap.dy};
    w_sx = $signed({2'b00, r_x}) + {w_dx9[8], w_dx9};
    if (Y_INVERT) w_sy = $signed({2'b00, r_y}) - {w_dy9[8], w_dy9};
    else          w_sy = $signed({2'b00, r_y}) + {w_dy9[8], w_dy9};
    w_nx = clamp(w_sx, X_MAX);
    w_ny = clamp(w_sy, Y_MAX);
    w_nz = r_z + {{4{r_snap.dz[3]}}, r_snap.dz[3:0]};
  end

  // Packet FSM, pending buffer, overrun flag and registered outputs.
  // NOTE: the reset is asynchronous, so it goes in the sensitivity list.
  // Every register here, the snapshot and pending buffer included, has a
  // defined reset value.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_pend      <= '0;
      r_pending   <= 1'b0;
      r_nx        <= '0;
      r_ny        <= '0;
      r_nz        <= '0;
      r_x         <= X_HOME;
      r_y         <= Y_HOME;
      r_z         <= '0;
      r_buttons   <= '0;
      r_pos_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register
      // samples the values from before the edge, whatever the statement
      // order. The later overrun set therefore overrides the clear.
      r_pos_valid <= 1'b0;
      if (OVERRUN_CLR) r_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            // A packet captured during COMMIT goes first. A new one in this
            // same cycle takes its place in the buffer.
            r_snap  <= r_pend;
            r_state <= S_CALC_X;
            if (SEND_INTERRUPT) r_pend    <= w_in;
            else                r_pending <= 1'b0;
          end else if (SEND_INTERRUPT) begin
            r_snap  <= w_in;
            r_state <= S_CALC_X;
          end
        end

        S_CALC_X, S_CALC_Y: begin
          if (r_state == S_CALC_X) begin
            r_nx    <= w_nx;
            r_state <= S_CALC_Y;
          end else begin
            r_ny    <= w_ny;
            r_nz    <= w_nz;
            r_state <= S_COMMIT;
          end
          if (SEND_INTERRUPT) begin
            r_pend    <= w_in;
            r_pending <= 1'b1;
            if (r_pending) r_overrun <= 1'b1;
          end
        end

        S_COMMIT: begin
          r_x         <= r_nx;
          r_y         <= r_ny;
          r_z         <= r_nz;
          r_buttons   <= r_snap.status[2:0];
          r_pos_valid <= 1'b1;
          if (r_pending) begin
            // A packet arriving now overwrites the pending one, so the
            // newest data goes straight into the snapshot.
            r_snap    <= SEND_INTERRUPT ? w_in : r_pend;
            r_pending <= 1'b0;
            r_state   <= S_CALC_X;
            if (SEND_INTERRUPT) r_overrun <= 1'b1;
          end else begin
            if (SEND_INTERRUPT) begin
              r_pend    <= w_in;
              r_pending <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MOUSE_X   = r_x;
  assign MOUSE_Y   = r_y;
  assign MOUSE_Z   = r_z;
  assign BUTTONS   = r_buttons;
  assign POS_VALID = r_pos_valid;
  assign OVERRUN   = r_overrun;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker with hand-computed expected
// values. Inputs change on the falling edge, and outputs are sampled on the
// falling edge.
module tb_mouse_position_tracker;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] MOUSE_STATUS = '0;
  logic [7:0] MOUSE_DX = '0;
  logic [7:0] MOUSE_DY = '0;
  logic [7:0] MOUSE_DZ = '0;
  logic       SEND_INTERRUPT = 1'b0;
  logic       OVERRUN_CLR = 1'b0;
  logic [7:0] MOUSE_X;
  logic [7:0] MOUSE_Y;
  logic [7:0] MOUSE_Z;
  logic [2:0] BUTTONS;
  logic       POS_VALID;
  logic       BUSY;
  logic       OVERRUN;

  int n_checks = 0;
  int n_errors = 0;

  mouse_position_tracker dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_DX       (MOUSE_DX),
    .MOUSE_DY       (MOUSE_DY),
    .MOUSE_DZ       (MOUSE_DZ),
    .SEND_INTERRUPT (SEND_INTERRUPT),
    .OVERRUN_CLR    (OVERRUN_CLR),
    .MOUSE_X        (MOUSE_X),
    .MOUSE_Y        (MOUSE_Y),
    .MOUSE_Z        (MOUSE_Z),
    .BUTTONS        (BUTTONS),
    .POS_VALID      (POS_VALID),
    .BUSY           (BUSY),
    .OVERRUN        (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    SEND_INTERRUPT = 1'b0;
    OVERRUN_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  // Presents one packet; the caller already sits on a falling edge.
  task automatic set_pkt(input logic [7:0] s, input logic [7:0] dx,
                         input logic [7:0] dy, input logic [7:0] dz);
    MOUSE_STATUS = s;
    MOUSE_DX = dx;
    MOUSE_DY = dy;
    MOUSE_DZ = dz;
    SEND_INTERRUPT = 1'b1;
  endtask

  // Sends one packet from IDLE and checks the 3-edge latency and the result.
  task automatic send_and_check(input string tag,
                                input logic [7:0] s, input logic [7:0] dx,
                                input logic [7:0] dy, input logic [7:0] dz,
                                input logic [7:0] ex, input logic [7:0] ey,
                                input logic [7:0] ez, input logic [2:0] eb);
    @(negedge CLK);
    set_pkt(s, dx, dy, dz);
    @(negedge CLK);            // edge k has sampled the interrupt
    SEND_INTERRUPT = 1'b0;
    @(negedge CLK);            // after edge k+1
    @(negedge CLK);            // after edge k+2
    check({tag, "_pv_early"}, POS_VALID, 1'b0);
    @(negedge CLK);            // after edge k+3
    check({tag, "_pv"}, POS_VALID, 1'b1);
    check({tag, "_x"}, MOUSE_X, ex);
    check({tag, "_y"}, MOUSE_Y, ey);
    check({tag, "_z"}, MOUSE_Z, ez);
    check({tag, "_btn"}, BUTTONS, eb);
    @(negedge CLK);
    check({tag, "_pv_end"}, POS_VALID, 1'b0);
    check({tag, "_busy_end"}, BUSY, 1'b0);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_x", MOUSE_X, 8'd80);
    check("rst_y", MOUSE_Y, 8'd60);
    check("rst_z", MOUSE_Z, 8'd0);
    check("rst_btn", BUTTONS, 3'd0);
    check("rst_pv", POS_VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_ovr", OVERRUN, 1'b0);

    // Basic packet: the X delta is +10; the Y delta is +5, so Y moves 60 -> 55.
    send_and_check("basic", 8'h01, 8'h0A, 8'h05, 8'h00, 8'd90, 8'd55, 8'd0, 3'b001);

    // Clamping, starting from the reset position
    do_reset();
    send_and_check("clamp_lo", 8'h10, 8'h80, 8'h00, 8'h00, 8'd0, 8'd60, 8'd0, 3'b000);
    send_and_check("clamp_hi1", 8'h00, 8'hFF, 8'h00, 8'h00, 8'd159, 8'd60, 8'd0, 3'b000);
    send_and_check("clamp_hi2", 8'h00, 8'hFF, 8'h00, 8'h00, 8'd159, 8'd60, 8'd0, 3'b000);
    send_and_check("clamp_hi3", 8'h00, 8'hFF, 8'h00, 8'h00, 8'd159, 8'd60, 8'd0, 3'b000);
    send_and_check("clamp_y", 8'h20, 8'h00, 8'h00, 8'h00, 8'd159, 8'd119, 8'd0, 3'b000);

    // X overflow drops only dx. The buttons still update, and Y moves 119 -> 103.
    send_and_check("ovf_x", 8'h47, 8'h50, 8'h10, 8'h00, 8'd159, 8'd103, 8'd0, 3'b111);

    // Wheel: 4-bit signed, wraps mod 256, and upper DZ bits are ignored
    do_reset();
    send_and_check("wheel_neg", 8'h00, 8'h00, 8'h00, 8'h0F, 8'd80, 8'd60, 8'hFF, 3'b000);
    send_and_check("wheel_wrap", 8'h00, 8'h00, 8'h00, 8'h02, 8'd80, 8'd60, 8'h01, 3'b000);
    send_and_check("wheel_hi", 8'h00, 8'h00, 8'h00, 8'hF1, 8'd80, 8'd60, 8'h02, 3'b000);

    // Interrupts at edges k and k+1: both packets apply, with commits at k+3 and k+6.
    do_reset();
    @(negedge CLK); set_pkt(8'h00, 8'h05, 8'h00, 8'h00);
    @(negedge CLK); set_pkt(8'h00, 8'h03, 8'h02, 8'h00);
    @(negedge CLK); SEND_INTERRUPT = 1'b0;            // after k+1
    @(negedge CLK);                                   // after k+2
    check("b2b_pv_k2", POS_VALID, 1'b0);
    @(negedge CLK);                                   // after k+3
    check("b2b_pv_k3", POS_VALID, 1'b1);
    check("b2b_x1", MOUSE_X, 8'd85);
    check("b2b_y1", MOUSE_Y, 8'd60);
    @(negedge CLK);
    check("b2b_pv_k4", POS_VALID, 1'b0);
    @(negedge CLK);
    check("b2b_pv_k5", POS_VALID, 1'b0);
    @(negedge CLK);                                   // after k+6
    check("b2b_pv_k6", POS_VALID, 1'b1);
    check("b2b_x2", MOUSE_X, 8'd88);
    check("b2b_y2", MOUSE_Y, 8'd58);
    check("b2b_ovr", OVERRUN, 1'b0);
    @(negedge CLK);
    check("b2b_busy", BUSY, 1'b0);

    // Interrupts at edges k, k+1 and k+2: the second packet is lost and OVERRUN is set.
    do_reset();
    @(negedge CLK); set_pkt(8'h00, 8'h01, 8'h00, 8'h00);
    @(negedge CLK); set_pkt(8'h00, 8'h02, 8'h00, 8'h00);
    @(negedge CLK); set_pkt(8'h00, 8'h04, 8'h00, 8'h00);
    @(negedge CLK); SEND_INTERRUPT = 1'b0;            // after k+2
    check("ovr_set", OVERRUN, 1'b1);
    @(negedge CLK);                                   // after k+3
    check("ovr_pv1", POS_VALID, 1'b1);
    check("ovr_x1", MOUSE_X, 8'd81);
    repeat (3) @(negedge CLK);                        // after k+6
    check("ovr_pv2", POS_VALID, 1'b1);
    check("ovr_x2", MOUSE_X, 8'd85);
    @(negedge CLK); OVERRUN_CLR = 1'b1;
    @(negedge CLK); OVERRUN_CLR = 1'b0;
    check("ovr_clr", OVERRUN, 1'b0);

    // An overwrite in the same cycle as OVERRUN_CLR keeps OVERRUN set.
    do_reset();
    @(negedge CLK); set_pkt(8'h00, 8'h01, 8'h00, 8'h00);
    @(negedge CLK); set_pkt(8'h00, 8'h02, 8'h00, 8'h00);
    @(negedge CLK); set_pkt(8'h00, 8'h04, 8'h00, 8'h00); OVERRUN_CLR = 1'b1;
    @(negedge CLK); SEND_INTERRUPT = 1'b0; OVERRUN_CLR = 1'b0;
    check("ovr_prio", OVERRUN, 1'b1);
    repeat (6) @(negedge CLK);

    // A packet arriving during COMMIT with nothing pending is kept and applied.
    do_reset();
    @(negedge CLK); set_pkt(8'h00, 8'h01, 8'h00, 8'h00);
    @(negedge CLK); SEND_INTERRUPT = 1'b0;            // after k
    repeat (2) @(negedge CLK);                        // after k+2, COMMIT next
    set_pkt(8'h00, 8'h02, 8'h00, 8'h00);
    @(negedge CLK); SEND_INTERRUPT = 1'b0;            // after k+3
    check("commit_pv", POS_VALID, 1'b1);
    check("commit_x1", MOUSE_X, 8'd81);
    repeat (8) @(negedge CLK);
    check("commit_x2", MOUSE_X, 8'd83);
    check("commit_ovr", OVERRUN, 1'b0);
    check("commit_busy", BUSY, 1'b0);

    // Reset during CALC_Y abandons the packet.
    @(negedge CLK); set_pkt(8'h01, 8'h0A, 8'h05, 8'h03);
    @(negedge CLK); SEND_INTERRUPT = 1'b0;            // after k: CALC_X
    @(negedge CLK);                                   // after k+1: CALC_Y
    check("mid_busy", BUSY, 1'b1);
    RESET = 1'b0;
    #1;
    check("mid_x", MOUSE_X, 8'd80);
    check("mid_y", MOUSE_Y, 8'd60);
    check("mid_z", MOUSE_Z, 8'd0);
    check("mid_btn", BUTTONS, 3'd0);
    check("mid_pv", POS_VALID, 1'b0);
    check("mid_busy0", BUSY, 1'b0);
    @(negedge CLK); RESET = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("mid_no_pv", POS_VALID, 1'b0);
    end
    check("mid_x_after", MOUSE_X, 8'd80);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
